// File: rtl/flash_pixel_stage_pkg.sv
// Shared definitions for the flash pixel stage.
//   - Default colour-index and RGB widths, and the default sync polarities.
//   - The 16-entry CGA palette (4-bit index -> 12-bit 4:4:4 RGB) and a lookup helper.
//   - A packed bundle type for the sync/active signals carried down the pipeline.
package flash_pixel_stage_pkg;

    localparam int unsigned IDX_W_DEFAULT = 4;
    localparam int unsigned RGB_W_DEFAULT = 12;
    localparam int unsigned PAL_ENTRIES   = 16;

    // 0 = active-low, the usual 640x480 VGA convention.
    localparam bit VSYNC_POL_DEFAULT = 1'b0;
    localparam bit HSYNC_POL_DEFAULT = 1'b0;

    typedef logic [11:0] rgb444_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
    } sync_bus_t;

    localparam rgb444_t CGA_PALETTE [PAL_ENTRIES] = '{
        12'h000, 12'h00A, 12'h0A0, 12'h0AA,
        12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF,
        12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
    };

    function automatic rgb444_t palette_lookup(input logic [3:0] idx);
        return CGA_PALETTE[idx];
    endfunction

endpackage

// File: rtl/flash_pixel_stage_if.sv
// Pixel stream interface between the text-mode timing/attribute front end and the
// flash pixel stage.
//   master : drives syncs, active flag, glyph bit, colour indices and attributes;
//            receives the delayed syncs/active and the final RGB.
//   slave  : the pixel stage itself (consumes the *In side, produces the *Out side).
interface flash_pixel_stage_if #(
    parameter int unsigned IDX_W = 4,
    parameter int unsigned RGB_W = 12
) ();

    logic             hsyncIn;
    logic             vsyncIn;
    logic             activeIn;
    logic             glyphBit;
    logic [IDX_W-1:0] fgIdx;
    logic [IDX_W-1:0] bgIdx;
    logic             blinkAttr;
    logic             cursorHere;

    logic [RGB_W-1:0] rgbOut;
    logic             hsyncOut;
    logic             vsyncOut;
    logic             activeOut;

    modport master (
        output hsyncIn, vsyncIn, activeIn, glyphBit, fgIdx, bgIdx, blinkAttr, cursorHere,
        input  rgbOut, hsyncOut, vsyncOut, activeOut
    );

    modport slave (
        input  hsyncIn, vsyncIn, activeIn, glyphBit, fgIdx, bgIdx, blinkAttr, cursorHere,
        output rgbOut, hsyncOut, vsyncOut, activeOut
    );

endinterface

// File: rtl/flash_pixel_stage_sync.sv
// Two-flop synchroniser for the slow flash level coming from another clock domain,
// plus a single-cycle rising-edge flag on the synchronised level.
//   clk_i   : destination (pixel) clock
//   rst_ni  : asynchronous active-low reset, all flops clear to 0
//   async_i : foreign-timing level
//   sync_o  : synchronised level (2-cycle delay)
//   rise_o  : high for one cycle when sync_o goes 0 -> 1
module flash_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = async_i;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/flash_pixel_stage.sv
// Pixel-output stage that applies character blink and cursor blink to the text-mode
// pixel stream. Blink phases are sampled only at frame start (vsync leading edge), so a
// visible frame always uses a single phase pair. Fixed 2-cycle latency, no stalls.
//   clock      : pixel clock
//   reset      : asynchronous active-low reset
//   flashClk   : slow flash level from flashHandler (foreign timing, synchronised here)
//   blinkEn    : 0 freezes blinking (characters visible, cursor hidden)
//   pix        : pixel stream interface (slave side): syncs/active/glyph/attrs in,
//                RGB and delayed syncs/active out
//   flashPhase : currently latched cursor phase
module flash_pixel_stage
    import flash_pixel_stage_pkg::*;
#(
    parameter int unsigned IDX_W     = IDX_W_DEFAULT,
    parameter int unsigned RGB_W     = RGB_W_DEFAULT,
    parameter bit          VSYNC_POL = VSYNC_POL_DEFAULT,
    parameter bit          HSYNC_POL = HSYNC_POL_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flashClk,
    input  logic                blinkEn,
    flash_pixel_stage_if.slave  pix,
    output logic                flashPhase
);

    // Idle level of the syncs, used as reset value so outputs sit deasserted.
    localparam sync_bus_t SyncIdle = '{hsync: ~HSYNC_POL, vsync: ~VSYNC_POL, active: 1'b0};

    logic flash_lvl;
    logic unused_flash_rise;

    flash_sync u_flash_sync (
        .clk_i   (clock),
        .rst_ni  (reset),
        .async_i (flashClk),
        .sync_o  (flash_lvl),
        .rise_o  (unused_flash_rise)
    );

    // Frame start detect and phase registers.
    logic      vsync_q, vsync_d;
    logic      flash_phase_q, flash_phase_d;
    logic      blink_phase_q, blink_phase_d;
    logic      frame_start;

    // Stage 1: colour index selection.
    sync_bus_t        s1_sync_q, s1_sync_d;
    logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
    logic             pix_on;

    // Stage 2: palette lookup and blanking.
    sync_bus_t        s2_sync_q, s2_sync_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic [3:0]       pal_idx;

    always_comb begin
        vsync_d     = pix.vsyncIn;
        frame_start = (pix.vsyncIn == VSYNC_POL) && (vsync_q == ~VSYNC_POL);

        flash_phase_d = flash_phase_q;
        blink_phase_d = blink_phase_q;
        if (!blinkEn) begin
            flash_phase_d = 1'b0;
            blink_phase_d = 1'b0;
        end else if (frame_start) begin
            flash_phase_d = flash_lvl;
            // Character blink toggles on each rising cursor phase: half the cursor rate.
            if (flash_lvl && !flash_phase_q) begin
                blink_phase_d = ~blink_phase_q;
            end
        end
    end

    always_comb begin
        pix_on = pix.glyphBit & ~(pix.blinkAttr & blink_phase_q);
        if (pix.cursorHere && flash_phase_q) begin
            pix_on = ~pix_on;
        end
        s1_idx_d  = pix_on ? pix.fgIdx : pix.bgIdx;
        s1_sync_d = '{hsync: pix.hsyncIn, vsync: pix.vsyncIn, active: pix.activeIn};
    end

    always_comb begin
        pal_idx   = 4'(s1_idx_q);
        rgb_d     = s1_sync_q.active ? RGB_W'(palette_lookup(pal_idx)) : '0;
        s2_sync_d = s1_sync_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vsync_q       <= ~VSYNC_POL;
            flash_phase_q <= 1'b0;
            blink_phase_q <= 1'b0;
            s1_sync_q     <= SyncIdle;
            s1_idx_q      <= '0;
            s2_sync_q     <= SyncIdle;
            rgb_q         <= '0;
        end else begin
            vsync_q       <= vsync_d;
            flash_phase_q <= flash_phase_d;
            blink_phase_q <= blink_phase_d;
            s1_sync_q     <= s1_sync_d;
            s1_idx_q      <= s1_idx_d;
            s2_sync_q     <= s2_sync_d;
            rgb_q         <= rgb_d;
        end
    end

    assign pix.rgbOut    = rgb_q;
    assign pix.hsyncOut  = s2_sync_q.hsync;
    assign pix.vsyncOut  = s2_sync_q.vsync;
    assign pix.activeOut = s2_sync_q.active;
    assign flashPhase    = flash_phase_q;

endmodule

// File: tb/tb_flash_pixel_stage.sv
module tb_flash_pixel_stage;

    localparam logic [11:0] FgRgb = 12'hFFF;  // palette[4'hF]
    localparam logic [11:0] BgRgb = 12'h00A;  // palette[4'h1]

    logic clock = 1'b0;
    logic reset;
    logic flashClk;
    logic blinkEn;
    logic flashPhase;

    int n_cmp = 0;
    int n_err = 0;
    logic exp_blink;

    flash_pixel_stage_if #(.IDX_W(4), .RGB_W(12)) pix_if ();

    flash_pixel_stage #(
        .IDX_W     (4),
        .RGB_W     (12),
        .VSYNC_POL (1'b0),
        .HSYNC_POL (1'b0)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .flashClk   (flashClk),
        .blinkEn    (blinkEn),
        .pix        (pix_if.slave),
        .flashPhase (flashPhase)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Blank lines, then a one-cycle vsync pulse (frame start), then back to visible.
    task automatic new_frame(input logic flash_val);
        pix_if.activeIn = 1'b0;
        flashClk        = flash_val;
        tick(4);
        pix_if.vsyncIn = 1'b0;
        tick(1);
        pix_if.vsyncIn  = 1'b1;
        pix_if.activeIn = 1'b1;
        tick(2);
    endtask

    initial begin
        // 1: reset with random inputs
        reset    = 1'b0;
        flashClk = 1'b0;
        blinkEn  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pix_if.hsyncIn    = 1'($urandom);
            pix_if.vsyncIn    = 1'($urandom);
            pix_if.activeIn   = 1'($urandom);
            pix_if.glyphBit   = 1'($urandom);
            pix_if.fgIdx      = 4'($urandom);
            pix_if.bgIdx      = 4'($urandom);
            pix_if.blinkAttr  = 1'($urandom);
            pix_if.cursorHere = 1'($urandom);
            flashClk          = 1'($urandom);
            blinkEn           = 1'($urandom);
            tick(1);
            check("rst_rgb", 32'(pix_if.rgbOut), 32'h0);
            check("rst_active", 32'(pix_if.activeOut), 32'h0);
            check("rst_hsync", 32'(pix_if.hsyncOut), 32'h1);
            check("rst_vsync", 32'(pix_if.vsyncOut), 32'h1);
            check("rst_phase", 32'(flashPhase), 32'h0);
        end

        pix_if.hsyncIn    = 1'b1;
        pix_if.vsyncIn    = 1'b1;
        pix_if.activeIn   = 1'b0;
        pix_if.glyphBit   = 1'b1;
        pix_if.fgIdx      = 4'hF;
        pix_if.bgIdx      = 4'h1;
        pix_if.blinkAttr  = 1'b0;
        pix_if.cursorHere = 1'b0;
        flashClk          = 1'b0;
        blinkEn           = 1'b0;
        reset             = 1'b1;
        tick(3);
        check("idle_rgb", 32'(pix_if.rgbOut), 32'h0);

        // 2: static, latency of first active pixel
        pix_if.activeIn = 1'b1;
        tick(1);
        check("lat1_active", 32'(pix_if.activeOut), 32'h0);
        check("lat1_rgb", 32'(pix_if.rgbOut), 32'h0);
        tick(1);
        check("lat2_active", 32'(pix_if.activeOut), 32'h1);
        check("static_fg", 32'(pix_if.rgbOut), 32'(FgRgb));
        pix_if.glyphBit = 1'b0;
        tick(2);
        check("static_bg", 32'(pix_if.rgbOut), 32'(BgRgb));
        pix_if.activeIn = 1'b0;
        tick(2);
        check("static_blank", 32'(pix_if.rgbOut), 32'h0);

        pix_if.hsyncIn = 1'b0;
        tick(1);
        check("hsync_d1", 32'(pix_if.hsyncOut), 32'h1);
        pix_if.hsyncIn = 1'b1;
        tick(1);
        check("hsync_d2", 32'(pix_if.hsyncOut), 32'h0);
        tick(1);
        check("hsync_back", 32'(pix_if.hsyncOut), 32'h1);

        // 3 + 5: frame alignment, cursor over background
        blinkEn           = 1'b1;
        pix_if.activeIn   = 1'b1;
        pix_if.cursorHere = 1'b1;
        tick(2);
        check("cur_off_bg", 32'(pix_if.rgbOut), 32'(BgRgb));
        flashClk = 1'b1;
        tick(5);
        check("mid_phase", 32'(flashPhase), 32'h0);
        check("mid_rgb", 32'(pix_if.rgbOut), 32'(BgRgb));
        pix_if.activeIn = 1'b0;
        tick(2);
        pix_if.vsyncIn = 1'b0;
        tick(1);
        check("fs_phase", 32'(flashPhase), 32'h1);
        check("vsync_d1", 32'(pix_if.vsyncOut), 32'h1);
        pix_if.vsyncIn  = 1'b1;
        pix_if.activeIn = 1'b1;
        tick(1);
        check("vsync_d2", 32'(pix_if.vsyncOut), 32'h0);
        tick(1);
        check("cur_on_fg", 32'(pix_if.rgbOut), 32'(FgRgb));

        // 4: char blink; the frame start above already toggled blink to 1
        exp_blink         = 1'b1;
        pix_if.cursorHere = 1'b0;
        pix_if.blinkAttr  = 1'b1;
        pix_if.glyphBit   = 1'b1;
        tick(2);
        check("blink_init", 32'(pix_if.rgbOut), 32'(BgRgb));
        for (int i = 0; i < 4; i++) begin
            new_frame(1'b0);
            check("blink_lo_phase", 32'(flashPhase), 32'h0);
            check("blink_lo_rgb", 32'(pix_if.rgbOut), 32'(exp_blink ? BgRgb : FgRgb));
            new_frame(1'b1);
            exp_blink = ~exp_blink;
            check("blink_hi_phase", 32'(flashPhase), 32'h1);
            check("blink_hi_rgb", 32'(pix_if.rgbOut), 32'(exp_blink ? BgRgb : FgRgb));
        end

        // 6: blinkEn drop with both phases high
        pix_if.blinkAttr  = 1'b0;
        pix_if.glyphBit   = 1'b0;
        pix_if.cursorHere = 1'b1;
        tick(2);
        check("pre_drop_cur", 32'(pix_if.rgbOut), 32'(FgRgb));
        blinkEn        = 1'b0;
        pix_if.hsyncIn = 1'b0;
        tick(1);
        check("drop_phase", 32'(flashPhase), 32'h0);
        check("drop_hsync1", 32'(pix_if.hsyncOut), 32'h1);
        pix_if.hsyncIn = 1'b1;
        tick(1);
        check("drop_old_pix", 32'(pix_if.rgbOut), 32'(FgRgb));
        check("drop_hsync2", 32'(pix_if.hsyncOut), 32'h0);
        tick(1);
        check("drop_cur_hidden", 32'(pix_if.rgbOut), 32'(BgRgb));
        pix_if.glyphBit  = 1'b1;
        pix_if.blinkAttr = 1'b1;
        tick(2);
        check("drop_glyph_vis", 32'(pix_if.rgbOut), 32'(FgRgb));
        new_frame(1'b1);
        check("drop_held_phase", 32'(flashPhase), 32'h0);

        // Resume, then reset mid-frame
        blinkEn = 1'b1;
        new_frame(1'b1);
        check("resume_phase", 32'(flashPhase), 32'h1);
        pix_if.blinkAttr  = 1'b0;
        pix_if.cursorHere = 1'b0;
        tick(2);
        reset = 1'b0;
        #1;
        check("mid_rst_rgb", 32'(pix_if.rgbOut), 32'h0);
        check("mid_rst_phase", 32'(flashPhase), 32'h0);
        tick(1);
        reset = 1'b1;
        tick(1);
        check("refill1_rgb", 32'(pix_if.rgbOut), 32'h0);
        tick(1);
        check("refill2_rgb", 32'(pix_if.rgbOut), 32'(FgRgb));
        check("refill_phase", 32'(flashPhase), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
